// File: rtl/dma_pkg.sv
// Shared types and constants for the multi-channel DMA controller.
// Holds the FSM state encoding, transfer direction codes and default widths.
package dma_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_REQ     = 2'd1,
        ST_XFER    = 2'd2,
        ST_RELEASE = 2'd3
    } dma_state_t;

    localparam logic DIR_IO2MEM = 1'b0;
    localparam logic DIR_MEM2IO = 1'b1;

    localparam int DEF_NUM_CH = 4;
    localparam int DEF_ADDR_W = 10;
    localparam int DEF_CNT_W  = 10;

endpackage

// File: rtl/dma_multi_channel_ctrl_if.sv
// System-side bus of the DMA controller: DREQ/DACK toward devices, HRQ/HLDA toward
// the CPU, plus the address buses and transfer strobes driven while holding the bus.
interface dma_multi_channel_ctrl_if #(
    parameter int NUM_CH = 4,
    parameter int ADDR_W = 10
);
    // Handshakes: HRQ is a level request held until HLDA is seen high; the bus is
    // owned only while both are high. DREQ is a level request answered by DACK for
    // the whole block, after which DREQ is no longer sampled for that block.
    logic [NUM_CH-1:0] DREQ;
    logic              HLDA;
    logic              HRQ;
    logic [NUM_CH-1:0] DACK;
    logic [ADDR_W-1:0] MEM_ADDR;
    logic [ADDR_W-1:0] IO_ADDR;
    logic              IOR;
    logic              IOW;
    logic              MEMR;
    logic              MEMW;
    logic              EOP_N;

    modport master (
        input  DREQ, HLDA,
        output HRQ, DACK, MEM_ADDR, IO_ADDR, IOR, IOW, MEMR, MEMW, EOP_N
    );

    modport slave (
        output DREQ, HLDA,
        input  HRQ, DACK, MEM_ADDR, IO_ADDR, IOR, IOW, MEMR, MEMW, EOP_N
    );

endinterface

// File: rtl/dma_arbiter.sv
// Channel arbiter: request vector in, one-hot grant out. DMA_RR_ARB_EN selects
// round-robin (pointer moves on block completion); otherwise fixed priority, ch0 first.
module dma_arbiter #(
    parameter int NUM_CH = 4
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NUM_CH-1:0]         req,
    input  logic                      upd,
    input  logic [$clog2(NUM_CH)-1:0] upd_ch,
    output logic [NUM_CH-1:0]         gnt
);

    localparam int CH_W = $clog2(NUM_CH);

`ifdef DMA_RR_ARB_EN
    logic [CH_W-1:0] last_q;

    // Reset to the top channel so channel 0 is first in line after reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_q <= CH_W'(NUM_CH - 1);
        end else if (upd) begin
            last_q <= upd_ch;
        end
    end

    always_comb begin
        int  idx;
        logic found;
        gnt   = '0;
        found = 1'b0;
        idx   = 0;
        for (int k = 1; k <= NUM_CH; k++) begin
            idx = (int'(last_q) + k) % NUM_CH;
            if (!found && req[idx]) begin
                gnt[idx] = 1'b1;
                found    = 1'b1;
            end
        end
    end
`else
    logic unused_rr;
    assign unused_rr = ^{clk, rst_n, upd, upd_ch};

    always_comb begin
        gnt = '0;
        for (int k = NUM_CH - 1; k >= 0; k--) begin
            if (req[k]) gnt = NUM_CH'(1) << k;
        end
    end
`endif

endmodule

// File: rtl/dma_multi_channel_ctrl.sv
// Multi-channel block DMA controller: arbitrates armed DREQs, takes the bus via
// HRQ/HLDA and moves one word per cycle. Arbitration mode follows DMA_RR_ARB_EN.
module dma_multi_channel_ctrl
    import dma_pkg::*;
#(
    parameter int NUM_CH = DEF_NUM_CH,
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int CNT_W  = DEF_CNT_W
) (
    input  logic                      CLK,
    input  logic                      RST_N,
    input  logic                      CFG_WE,
    input  logic [$clog2(NUM_CH)-1:0] CFG_CH,
    input  logic [ADDR_W-1:0]         CFG_MEM_ADDR,
    input  logic [ADDR_W-1:0]         CFG_IO_ADDR,
    input  logic [CNT_W-1:0]          CFG_COUNT,
    input  logic                      CFG_DIR,
    output logic [NUM_CH-1:0]         DONE,
    input  logic [NUM_CH-1:0]         DONE_CLR,
    dma_multi_channel_ctrl_if.master  bus,
    output dma_state_t                dbg_state
);

    localparam int CH_W = $clog2(NUM_CH);

    logic [ADDR_W-1:0] mem_addr_q [NUM_CH];
    logic [ADDR_W-1:0] io_addr_q  [NUM_CH];
    logic [CNT_W-1:0]  count_q    [NUM_CH];
    logic [NUM_CH-1:0] dir_q;
    logic [NUM_CH-1:0] armed;
    logic [NUM_CH-1:0] req;
    logic [NUM_CH-1:0] gnt_oh;
    logic [CH_W-1:0]   gnt_idx;
    logic [CH_W-1:0]   grant_q;
    dma_state_t        state_q, state_d;
    logic              issue, latch_grant, last_word, blk_done, chan_busy;

    always_comb begin
        for (int i = 0; i < NUM_CH; i++) armed[i] = (count_q[i] != '0);
    end
    assign req = armed & bus.DREQ;

    dma_arbiter #(.NUM_CH(NUM_CH)) u_arb (
        .clk    (CLK),
        .rst_n  (RST_N),
        .req    (req),
        .upd    (blk_done),
        .upd_ch (grant_q),
        .gnt    (gnt_oh)
    );

    always_comb begin
        gnt_idx = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (gnt_oh[i]) gnt_idx = CH_W'(i);
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    // Entering XFER always moves a word; a cycle in XFER whose count is already
    // zero means the last word went out on the previous edge.
    always_comb begin
        state_d     = state_q;
        issue       = 1'b0;
        latch_grant = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (|req) begin
                    state_d     = ST_REQ;
                    latch_grant = 1'b1;
                end
            end
            ST_REQ: begin
                if (bus.HLDA) begin
                    state_d = ST_XFER;
                    issue   = 1'b1;
                end
            end
            ST_XFER: begin
                if (count_q[grant_q] == '0) state_d = ST_RELEASE;
                else if (bus.HLDA)          issue   = 1'b1;
                else                        state_d = ST_REQ;
            end
            ST_RELEASE: begin
                if (!bus.HLDA) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign last_word = (count_q[grant_q] == CNT_W'(1));
    assign blk_done  = issue && last_word;
    assign chan_busy = (state_q != ST_IDLE);
    assign dbg_state = state_q;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            for (int i = 0; i < NUM_CH; i++) begin
                mem_addr_q[i] <= '0;
                io_addr_q[i]  <= '0;
                count_q[i]    <= '0;
            end
            dir_q   <= '0;
            grant_q <= '0;
            DONE    <= '0;
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (CFG_WE && CFG_CH == CH_W'(i) && !(chan_busy && grant_q == CH_W'(i))) begin
                    mem_addr_q[i] <= CFG_MEM_ADDR;
                    io_addr_q[i]  <= CFG_IO_ADDR;
                    count_q[i]    <= CFG_COUNT;
                    dir_q[i]      <= CFG_DIR;
                end else if (issue && grant_q == CH_W'(i)) begin
                    mem_addr_q[i] <= mem_addr_q[i] + ADDR_W'(1);
                    io_addr_q[i]  <= io_addr_q[i] + ADDR_W'(1);
                    count_q[i]    <= count_q[i] - CNT_W'(1);
                end
                if (blk_done && grant_q == CH_W'(i)) DONE[i] <= 1'b1;
                else if (DONE_CLR[i])                DONE[i] <= 1'b0;
            end
            if (latch_grant) grant_q <= gnt_idx;
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            bus.HRQ      <= 1'b0;
            bus.DACK     <= '0;
            bus.MEM_ADDR <= '0;
            bus.IO_ADDR  <= '0;
            bus.IOR      <= 1'b0;
            bus.IOW      <= 1'b0;
            bus.MEMR     <= 1'b0;
            bus.MEMW     <= 1'b0;
            bus.EOP_N    <= 1'b1;
        end else begin
            bus.HRQ   <= (state_d == ST_REQ) || (state_d == ST_XFER);
            bus.DACK  <= (state_d == ST_XFER) ? (NUM_CH'(1) << grant_q) : '0;
            bus.IOR   <= issue && (dir_q[grant_q] == DIR_IO2MEM);
            bus.MEMW  <= issue && (dir_q[grant_q] == DIR_IO2MEM);
            bus.MEMR  <= issue && (dir_q[grant_q] == DIR_MEM2IO);
            bus.IOW   <= issue && (dir_q[grant_q] == DIR_MEM2IO);
            bus.EOP_N <= !blk_done;
            if (issue) begin
                bus.MEM_ADDR <= mem_addr_q[grant_q];
                bus.IO_ADDR  <= io_addr_q[grant_q];
            end
        end
    end

endmodule
